// File: rtl/writeback_stage_if.sv
// ----------------------------------------------------------------------------
// writeback_stage_if
//   Bundle carrying retiring instructions from the memory stage into the
//   writeback stage.
//
//   Handshake: the memory stage (master) raises in_valid with all in_*
//   payload fields stable. The writeback stage (slave) drives in_ready.
//   A transfer happens on a rising clk edge where in_valid && in_ready are
//   both high. The writeback stage may additionally discard the offered
//   instruction with its own flush input.
//
//   Signals
//     in_valid        master -> slave  instruction offered
//     in_ready        slave  -> master stage can accept this cycle
//     in_pc_notbranch master -> slave  fall-through PC
//     in_pc_branch    master -> slave  branch/jump target
//     in_br_taken     master -> slave  branch resolved taken
//     in_wen          master -> slave  instruction writes rd
//     in_rd_addr      master -> slave  destination register
//     in_wb_sel       master -> slave  write-back source select
//     in_alu_res      master -> slave  ALU result
//     in_load_data    master -> slave  raw aligned load data
//     in_load_fmt     master -> slave  load size / signedness code
//     in_addr_lo      master -> slave  low load-address bits (lane select)
// ----------------------------------------------------------------------------
interface writeback_stage_if #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc_notbranch;
  logic [XLEN-1:0] in_pc_branch;
  logic            in_br_taken;
  logic            in_wen;
  logic [RA_W-1:0] in_rd_addr;
  logic [1:0]      in_wb_sel;
  logic [XLEN-1:0] in_alu_res;
  logic [XLEN-1:0] in_load_data;
  logic [2:0]      in_load_fmt;
  logic [2:0]      in_addr_lo;

  modport master (
    output in_valid, in_pc_notbranch, in_pc_branch, in_br_taken, in_wen,
           in_rd_addr, in_wb_sel, in_alu_res, in_load_data, in_load_fmt,
           in_addr_lo,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_pc_notbranch, in_pc_branch, in_br_taken, in_wen,
           in_rd_addr, in_wb_sel, in_alu_res, in_load_data, in_load_fmt,
           in_addr_lo,
    output in_ready
  );
endinterface

// File: rtl/writeback_stage.sv
// ----------------------------------------------------------------------------
// writeback_stage
//   Final pipeline stage. Accepts one retiring instruction per cycle, picks
//   the next PC, formats the register write-back value (ALU / load / link)
//   and drives the register-file write port, which doubles as the
//   forwarding source. Counts retired instructions.
//
//   Ports
//     clk, rst_n      clock, asynchronous active-low reset
//     bus             writeback_stage_if.slave, instruction input + in_ready
//     stall           hold: nothing is accepted, in_ready low
//     flush           discard the instruction offered this cycle
//     next_pc         registered next PC (RESET_PC after reset)
//     pc_valid        1-cycle pulse, next_pc updated
//     redirect        1-cycle pulse, accepted instruction was a taken branch
//     write_reg       1-cycle register-file write enable
//     dstreg_addr     register-file write address
//     dstreg_data     register-file write data
//     retire_count    accepted-instruction counter (wraps)
//
//   Accept = in_valid & in_ready & !flush; results are visible the cycle
//   after the accepting edge. in_ready is the only combinational output.
// ----------------------------------------------------------------------------
module writeback_stage #(
  parameter int          XLEN     = 32,
  parameter int          RA_W     = 5,
  parameter int          CNT_W    = 32,
  parameter logic [63:0] RESET_PC = 64'd0,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  writeback_stage_if.slave bus,
  input  logic             stall,
  input  logic             flush,
  output logic [XLEN-1:0]  next_pc,
  output logic             pc_valid,
  output logic             redirect,
  output logic             write_reg,
  output logic [RA_W-1:0]  dstreg_addr,
  output logic [XLEN-1:0]  dstreg_data,
  output logic [CNT_W-1:0] retire_count
);

  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_LINK = 2'b10;

  localparam logic [2:0] FMT_LB  = 3'b000;
  localparam logic [2:0] FMT_LH  = 3'b001;
  localparam logic [2:0] FMT_LD  = 3'b011;
  localparam logic [2:0] FMT_LBU = 3'b100;
  localparam logic [2:0] FMT_LHU = 3'b101;
  localparam logic [2:0] FMT_LWU = 3'b110;

  logic            accept;
  logic            wr_en;
  logic [2:0]      lane;
  logic [63:0]     raw64;
  logic [63:0]     byte_sh;
  logic [63:0]     half_sh;
  logic [63:0]     word_sh;
  logic [63:0]     ld64;
  logic [XLEN-1:0] wb_data;

  assign bus.in_ready = !stall;
  // Flush wins over in_valid: a flushed instruction changes no state.
  assign accept = bus.in_valid && !stall && !flush;
  assign wr_en  = bus.in_wen && !(ZERO_REG && (bus.in_rd_addr == '0));

  // Load formatting is done on a 64-bit view so one datapath serves both
  // XLEN values; the result is truncated to XLEN afterwards. With XLEN=32
  // the upper lane bit is forced low so only the single word is addressed.
  always_comb begin
    raw64 = '0;
    raw64[XLEN-1:0] = bus.in_load_data;
    lane = bus.in_addr_lo;
    if (XLEN == 32) lane[2] = 1'b0;
    byte_sh = raw64 >> {lane, 3'b000};
    half_sh = raw64 >> {lane[2:1], 4'b0000};
    word_sh = raw64 >> {lane[2], 5'b00000};
    case (bus.in_load_fmt)
      FMT_LB:  ld64 = {{56{byte_sh[7]}}, byte_sh[7:0]};
      FMT_LBU: ld64 = {56'd0, byte_sh[7:0]};
      FMT_LH:  ld64 = {{48{half_sh[15]}}, half_sh[15:0]};
      FMT_LHU: ld64 = {48'd0, half_sh[15:0]};
      // Zero-extension is invisible after truncation to 32 bits, so LWU
      // naturally degrades to LW there.
      FMT_LWU: ld64 = {32'd0, word_sh[31:0]};
      FMT_LD:  ld64 = (XLEN == 64) ? raw64
                                   : {{32{word_sh[31]}}, word_sh[31:0]};
      // LW and the undefined code 111
      default: ld64 = {{32{word_sh[31]}}, word_sh[31:0]};
    endcase
  end

  always_comb begin
    case (bus.in_wb_sel)
      SEL_LOAD: wb_data = ld64[XLEN-1:0];
      SEL_LINK: wb_data = bus.in_pc_notbranch;
      default:  wb_data = bus.in_alu_res;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_pc      <= RESET_PC[XLEN-1:0];
      pc_valid     <= 1'b0;
      redirect     <= 1'b0;
      write_reg    <= 1'b0;
      dstreg_addr  <= '0;
      dstreg_data  <= '0;
      retire_count <= '0;
    end else begin
      pc_valid  <= accept;
      redirect  <= accept && bus.in_br_taken;
      write_reg <= accept && wr_en;
      if (accept) begin
        next_pc      <= bus.in_br_taken ? bus.in_pc_branch : bus.in_pc_notbranch;
        dstreg_addr  <= bus.in_rd_addr;
        dstreg_data  <= wb_data;
        retire_count <= retire_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;

  localparam int          XLEN     = 32;
  localparam int          RA_W     = 5;
  localparam int          CNT_W    = 4;
  localparam logic [63:0] RESET_PC = 64'h80;

  typedef struct {
    logic            wen;
    logic [RA_W-1:0] rd;
    logic [1:0]      sel;
    logic [2:0]      fmt;
    logic [2:0]      lo;
    logic            taken;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] ld;
    logic [XLEN-1:0] pcn;
    logic [XLEN-1:0] pcb;
    logic [XLEN-1:0] exp_data;
    logic            exp_wr;
  } vec_t;

  typedef struct packed {
    logic             pc_valid;
    logic             redirect;
    logic             write_reg;
    logic [XLEN-1:0]  next_pc;
    logic [RA_W-1:0]  addr;
    logic [XLEN-1:0]  data;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  localparam int EW = $bits(exp_t);

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             stall, flush;
  logic [XLEN-1:0]  next_pc, dstreg_data;
  logic             pc_valid, redirect, write_reg;
  logic [RA_W-1:0]  dstreg_addr;
  logic [CNT_W-1:0] retire_count;

  writeback_stage_if #(.XLEN(XLEN), .RA_W(RA_W)) wbi ();

  writeback_stage #(
    .XLEN(XLEN), .RA_W(RA_W), .CNT_W(CNT_W), .RESET_PC(RESET_PC), .ZERO_REG(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(wbi.slave), .stall(stall), .flush(flush),
    .next_pc(next_pc), .pc_valid(pc_valid), .redirect(redirect),
    .write_reg(write_reg), .dstreg_addr(dstreg_addr), .dstreg_data(dstreg_data),
    .retire_count(retire_count)
  );

  // scoreboard state
  logic [EW-1:0]    exp_q[$];
  int               n_checks = 0;
  int               n_fail = 0;
  logic [XLEN-1:0]  m_pc;
  logic [RA_W-1:0]  m_addr;
  logic [XLEN-1:0]  m_data;
  logic [CNT_W-1:0] m_cnt;
  vec_t             vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic wen, input logic [RA_W-1:0] rd,
                              input logic [1:0] sel, input logic [2:0] fmt,
                              input logic [2:0] lo, input logic taken,
                              input logic [XLEN-1:0] alu, input logic [XLEN-1:0] ld,
                              input logic [XLEN-1:0] exp_data, input logic exp_wr);
    vec_t v;
    v.wen = wen; v.rd = rd; v.sel = sel; v.fmt = fmt; v.lo = lo; v.taken = taken;
    v.alu = alu; v.ld = ld; v.pcn = 32'h104; v.pcb = 32'h200;
    v.exp_data = exp_data; v.exp_wr = exp_wr;
    return v;
  endfunction

  task automatic model_reset();
    m_pc = RESET_PC[XLEN-1:0];
    m_addr = '0;
    m_data = '0;
    m_cnt = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_next_pc"}, 64'(next_pc), RESET_PC);
    chk({tag, "_pc_valid"}, 64'(pc_valid), 64'd0);
    chk({tag, "_redirect"}, 64'(redirect), 64'd0);
    chk({tag, "_write_reg"}, 64'(write_reg), 64'd0);
    chk({tag, "_dstreg_addr"}, 64'(dstreg_addr), 64'd0);
    chk({tag, "_dstreg_data"}, 64'(dstreg_data), 64'd0);
    chk({tag, "_retire_count"}, 64'(retire_count), 64'd0);
  endtask

  // driver: one cycle of stimulus, expectation pushed, DUT result popped
  task automatic step(input vec_t v, input logic vld, input logic stl, input logic fls);
    logic acc;
    exp_t e;
    @(negedge clk);
    wbi.in_valid        = vld;
    wbi.in_pc_notbranch = v.pcn;
    wbi.in_pc_branch    = v.pcb;
    wbi.in_br_taken     = v.taken;
    wbi.in_wen          = v.wen;
    wbi.in_rd_addr      = v.rd;
    wbi.in_wb_sel       = v.sel;
    wbi.in_alu_res      = v.alu;
    wbi.in_load_data    = v.ld;
    wbi.in_load_fmt     = v.fmt;
    wbi.in_addr_lo      = v.lo;
    stall               = stl;
    flush               = fls;
    #1;
    chk("in_ready", 64'(wbi.in_ready), 64'(!stl));
    acc = vld && !stl && !fls;
    if (acc) begin
      m_pc   = v.taken ? v.pcb : v.pcn;
      m_addr = v.rd;
      m_data = v.exp_data;
      m_cnt  = m_cnt + 1'b1;
    end
    e.pc_valid  = acc;
    e.redirect  = acc && v.taken;
    e.write_reg = acc && v.exp_wr;
    e.next_pc   = m_pc;
    e.addr      = m_addr;
    e.data      = m_data;
    e.cnt       = m_cnt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("queue_empty", 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      chk("pc_valid", 64'(pc_valid), 64'(e.pc_valid));
      chk("redirect", 64'(redirect), 64'(e.redirect));
      chk("write_reg", 64'(write_reg), 64'(e.write_reg));
      chk("next_pc", 64'(next_pc), 64'(e.next_pc));
      chk("dstreg_addr", 64'(dstreg_addr), 64'(e.addr));
      chk("dstreg_data", 64'(dstreg_data), 64'(e.data));
      chk("retire_count", 64'(retire_count), 64'(e.cnt));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    logic [XLEN-1:0] raw;
    raw = 32'h80FF7F01;

    // wen rd sel fmt lo taken alu ld exp_data exp_wr
    vecs.push_back(mk(1, 7, 2'b00, 3'b000, 0, 0, 32'h1234, raw, 32'h0000_1234, 1)); // ALU
    vecs.push_back(mk(1, 0, 2'b00, 3'b000, 0, 0, 32'hDEAD, raw, 32'h0000_DEAD, 0)); // x0
    vecs.push_back(mk(1, 3, 2'b01, 3'b000, 1, 0, 0, raw, 32'h0000_007F, 1));        // LB lo1
    vecs.push_back(mk(1, 3, 2'b01, 3'b000, 3, 0, 0, raw, 32'hFFFF_FF80, 1));        // LB lo3
    vecs.push_back(mk(1, 4, 2'b01, 3'b100, 3, 0, 0, raw, 32'h0000_0080, 1));        // LBU lo3
    vecs.push_back(mk(1, 5, 2'b01, 3'b000, 2, 0, 0, raw, 32'hFFFF_FFFF, 1));        // LB lo2
    vecs.push_back(mk(1, 5, 2'b01, 3'b100, 0, 0, 0, raw, 32'h0000_0001, 1));        // LBU lo0
    vecs.push_back(mk(1, 6, 2'b01, 3'b001, 2, 0, 0, raw, 32'hFFFF_80FF, 1));        // LH lo2
    vecs.push_back(mk(1, 6, 2'b01, 3'b101, 2, 0, 0, raw, 32'h0000_80FF, 1));        // LHU lo2
    vecs.push_back(mk(1, 6, 2'b01, 3'b001, 3, 0, 0, raw, 32'hFFFF_80FF, 1));        // LH lo3
    vecs.push_back(mk(1, 6, 2'b01, 3'b001, 0, 0, 0, raw, 32'h0000_7F01, 1));        // LH lo0
    vecs.push_back(mk(1, 8, 2'b01, 3'b010, 1, 0, 0, raw, 32'h80FF_7F01, 1));        // LW
    vecs.push_back(mk(1, 8, 2'b01, 3'b011, 0, 0, 0, raw, 32'h80FF_7F01, 1));        // LD as LW
    vecs.push_back(mk(1, 8, 2'b01, 3'b110, 0, 0, 0, raw, 32'h80FF_7F01, 1));        // LWU as LW
    vecs.push_back(mk(1, 8, 2'b01, 3'b111, 0, 0, 0, raw, 32'h80FF_7F01, 1));        // 111 as LW
    vecs.push_back(mk(1, 1, 2'b10, 3'b000, 0, 1, 32'h9, raw, 32'h0000_0104, 1));    // link, taken
    vecs.push_back(mk(1, 9, 2'b11, 3'b000, 0, 1, 32'h55, raw, 32'h0000_0055, 1));   // sel11 taken
    vecs.push_back(mk(0, 9, 2'b00, 3'b000, 0, 0, 32'h77, raw, 32'h0000_0077, 0));   // wen=0

    // reset state
    wbi.in_valid = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    model_reset();
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // five accepts, then asynchronous reset in the middle of a cycle
    for (int i = 0; i < 5; i++) step(vecs[0], 1, 0, 0);
    chk("count_before_reset", 64'(retire_count), 64'd5);
    #2;
    wbi.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_outputs("midrun_reset");
    @(negedge clk);
    rst_n = 1'b1;

    // table-driven vectors
    for (int i = 0; i < vecs.size(); i++) step(vecs[i], 1, 0, 0);

    // valid held under stall for three cycles, then accepted
    v = mk(1, 12, 2'b00, 3'b000, 0, 1, 32'hCAFE, raw, 32'h0000_CAFE, 1);
    for (int i = 0; i < 3; i++) step(v, 1, 1, 0);
    step(v, 1, 0, 0);

    // flush, stall+flush, idle: no trace
    v = mk(1, 13, 2'b00, 3'b000, 0, 1, 32'hBAD0, raw, 32'h0000_BAD0, 1);
    v.pcb = 32'h400;
    step(v, 1, 0, 1);
    step(v, 1, 1, 1);
    step(v, 0, 0, 0);

    // back-to-back accepts, then random ALU traffic (counter wraps)
    step(mk(1, 14, 2'b00, 3'b000, 0, 0, 32'h1111, raw, 32'h0000_1111, 1), 1, 0, 0);
    step(mk(1, 15, 2'b00, 3'b000, 0, 0, 32'h2222, raw, 32'h0000_2222, 1), 1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      logic [XLEN-1:0] a;
      logic [RA_W-1:0] r;
      logic            t;
      a = $urandom();
      r = RA_W'($urandom_range(0, 31));
      t = 1'($urandom_range(0, 1));
      v = mk(1, r, 2'b00, 3'b000, 0, t, a, raw, a, r != 0);
      v.pcb = $urandom();
      v.pcn = $urandom();
      step(v, 1, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
